// File: rtl/ctrl_pipe_chain_pkg.sv
// Shared constants and helpers for the control-word pipeline chain.
// Ports: none (package). Holds the stage-count limit and the valid-bit popcount.
// Only the stage-count limit lives here; control-word field layout belongs to the decoder.
package ctrl_pipe_chain_pkg;

  // Largest supported chain depth; the popcount below is sized for it.
  localparam int unsigned MAX_STAGES = 8;

  // Number of set bits in a valid vector, zero-extended to MAX_STAGES bits.
  function automatic logic [3:0] count_ones(input logic [MAX_STAGES-1:0] vec);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      n = n + {3'b000, vec[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage: control word plus valid bit, priority clear > hold > load.
// Ports: clk/rst (async active-high), clr (flush or bubble), hold, d/v (source word/valid),
//        q/q_valid (registered stage), v_next (valid this stage takes at the next edge).
module ctrl_stage_reg #(
  parameter int WIDTH    = 15,
  parameter bit CLR_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             hold,
  input  logic [WIDTH-1:0] d,
  input  logic             v,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             v_next
);

  logic [WIDTH-1:0] dat_d, dat_q;
  logic             vld_d, vld_q;

  always_comb begin
    dat_d = dat_q;
    vld_d = vld_q;
    if (clr) begin
      // Clear wins over hold: a flushed, held stage becomes a held bubble.
      vld_d = 1'b0;
      if (CLR_DATA) begin
        dat_d = '0;
      end
    end else if (!hold) begin
      vld_d = v;
      dat_d = d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_q <= '0;
      vld_q <= 1'b0;
    end else begin
      dat_q <= dat_d;
      vld_q <= vld_d;
    end
  end

  assign q       = dat_q;
  assign q_valid = vld_q;
  assign v_next  = vld_d;

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Parametrised chain of decoded control-word registers (stage 0 = E, 1 = M, 2 = W, ...)
// with per-stage stall/flush, bubble insertion behind a stall, and a registered occupancy.
// Ports: clk, rst (async active-high); d_in/d_valid/d_ready from decode; stall/flush per stage;
//        q (stage i at [(i+1)*WIDTH-1 : i*WIDTH]), q_valid per stage, occupancy = popcount(q_valid).
module ctrl_pipe_chain
  import ctrl_pipe_chain_pkg::*;
#(
  parameter int WIDTH    = 15,
  parameter int STAGES   = 3,
  parameter bit CLR_DATA = 1'b1,
  localparam int OW      = $clog2(STAGES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        d_in,
  input  logic                    d_valid,
  output logic                    d_ready,
  input  logic [STAGES-1:0]       stall,
  input  logic [STAGES-1:0]       flush,
  output logic [STAGES*WIDTH-1:0] q,
  output logic [STAGES-1:0]       q_valid,
  output logic [OW-1:0]           occupancy
);

  // hold[i]: stage i cannot advance because it or anything downstream is stalled.
  logic [STAGES:0]            hold;
  logic [STAGES-1:0]          v_next;
  logic [MAX_STAGES-1:0]      v_ext;
  logic [OW-1:0]              occ_d, occ_q;

  assign hold[STAGES] = 1'b0;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic [WIDTH-1:0] src_dat;
    logic             src_vld;
    logic             clr;

    assign hold[i] = stall[i] | hold[i+1];

    if (i == 0) begin : g_head
      assign src_dat = d_in;
      assign src_vld = d_valid;
      assign clr     = flush[0];
    end else begin : g_body
      assign src_dat = q[(i-1)*WIDTH +: WIDTH];
      assign src_vld = q_valid[i-1];
      // Upstream frozen while this stage is free to move: drain into a bubble.
      assign clr     = flush[i] | (stall[i-1] & ~hold[i]);
    end

    ctrl_stage_reg #(
      .WIDTH    (WIDTH),
      .CLR_DATA (CLR_DATA)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .hold    (hold[i]),
      .d       (src_dat),
      .v       (src_vld),
      .q       (q[i*WIDTH +: WIDTH]),
      .q_valid (q_valid[i]),
      .v_next  (v_next[i])
    );
  end

  assign d_ready = ~hold[0];

  // Counting next-state valids keeps the registered count in step with q_valid.
  always_comb begin
    v_ext = '0;
    v_ext[STAGES-1:0] = v_next;
  end

  assign occ_d = OW'(count_ones(v_ext));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
module tb_ctrl_pipe_chain;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Four configurations: 0 = 15x3 clear, 1 = 15x3 hold data, 2 = 32x5 clear, 3 = 32x1 hold data.
  int cfg_s [4] = '{3, 3, 5, 1};
  int cfg_w [4] = '{15, 15, 32, 32};
  bit cfg_c [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  logic [31:0] din [4];
  logic        dv  [4];
  logic [7:0]  st  [4];
  logic [7:0]  fl  [4];

  logic [44:0]  q_a, q_b;
  logic [159:0] q_c;
  logic [31:0]  q_d;
  logic [2:0]   qv_a, qv_b;
  logic [4:0]   qv_c;
  logic [0:0]   qv_d;
  logic [1:0]   occ_a, occ_b;
  logic [2:0]   occ_c;
  logic [0:0]   occ_d;
  logic         rdy_a, rdy_b, rdy_c, rdy_d;

  ctrl_pipe_chain #(.WIDTH(15), .STAGES(3), .CLR_DATA(1'b1)) dut_a (
    .clk(clk), .rst(rst), .d_in(din[0][14:0]), .d_valid(dv[0]), .d_ready(rdy_a),
    .stall(st[0][2:0]), .flush(fl[0][2:0]), .q(q_a), .q_valid(qv_a), .occupancy(occ_a));
  ctrl_pipe_chain #(.WIDTH(15), .STAGES(3), .CLR_DATA(1'b0)) dut_b (
    .clk(clk), .rst(rst), .d_in(din[1][14:0]), .d_valid(dv[1]), .d_ready(rdy_b),
    .stall(st[1][2:0]), .flush(fl[1][2:0]), .q(q_b), .q_valid(qv_b), .occupancy(occ_b));
  ctrl_pipe_chain #(.WIDTH(32), .STAGES(5), .CLR_DATA(1'b1)) dut_c (
    .clk(clk), .rst(rst), .d_in(din[2]), .d_valid(dv[2]), .d_ready(rdy_c),
    .stall(st[2][4:0]), .flush(fl[2][4:0]), .q(q_c), .q_valid(qv_c), .occupancy(occ_c));
  ctrl_pipe_chain #(.WIDTH(32), .STAGES(1), .CLR_DATA(1'b0)) dut_d (
    .clk(clk), .rst(rst), .d_in(din[3]), .d_valid(dv[3]), .d_ready(rdy_d),
    .stall(st[3][0:0]), .flush(fl[3][0:0]), .q(q_d), .q_valid(qv_d), .occupancy(occ_d));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: per-stage word and valid, advanced by the stage rules.
  logic [31:0] md [4][8];
  bit          mv [4][8];

  task automatic model_reset();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 8; i++) begin
        md[k][i] = '0;
        mv[k][i] = 1'b0;
      end
  endtask

  // True when stage i of configuration k is frozen by itself or anything after it.
  function automatic bit frozen(int k, int i);
    for (int j = i; j < cfg_s[k]; j++)
      if (st[k][j]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input int k);
    logic [31:0] nd [8];
    bit          nv [8];
    for (int i = 0; i < cfg_s[k]; i++) begin
      nd[i] = md[k][i];
      nv[i] = mv[k][i];
      if (fl[k][i] || (i > 0 && !frozen(k, i) && st[k][i-1])) begin
        nv[i] = 1'b0;
        if (cfg_c[k]) nd[i] = '0;
      end else if (!frozen(k, i)) begin
        nv[i] = (i == 0) ? dv[k] : mv[k][i-1];
        nd[i] = (i == 0) ? din[k] : md[k][i-1];
      end
    end
    for (int i = 0; i < cfg_s[k]; i++) begin
      md[k][i] = nd[i];
      mv[k][i] = nv[i];
    end
  endtask

  function automatic logic get_rdy(int k);
    case (k)
      0: return rdy_a;
      1: return rdy_b;
      2: return rdy_c;
      default: return rdy_d;
    endcase
  endfunction

  task automatic check_dut(input int k);
    logic [255:0] gq, gv, go, eq, ev, eo;
    case (k)
      0: begin gq = 256'(q_a); gv = 256'(qv_a); go = 256'(occ_a); end
      1: begin gq = 256'(q_b); gv = 256'(qv_b); go = 256'(occ_b); end
      2: begin gq = 256'(q_c); gv = 256'(qv_c); go = 256'(occ_c); end
      default: begin gq = 256'(q_d); gv = 256'(qv_d); go = 256'(occ_d); end
    endcase
    eq = '0; ev = '0; eo = '0;
    for (int i = 0; i < cfg_s[k]; i++) begin
      for (int b = 0; b < cfg_w[k]; b++) eq[i*cfg_w[k] + b] = md[k][i][b];
      ev[i] = mv[k][i];
      eo = eo + 256'(mv[k][i]);
    end
    check($sformatf("q%0d", k), gq, eq);
    check($sformatf("q_valid%0d", k), gv, ev);
    check($sformatf("occupancy%0d", k), go, eo);
  endtask

  // Check ready against current inputs, advance the model, clock, check state.
  task automatic step();
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("d_ready%0d", k), 256'(get_rdy(k)), 256'(!frozen(k, 0)));
      model_step(k);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) check_dut(k);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    for (int k = 0; k < 4; k++) check_dut(k);
    #1 rst = 1'b0;
  endtask

  // Directed stimulus goes to the two 3-stage instances; the others idle.
  task automatic drive(input logic [31:0] d, input logic v, input logic [7:0] s, input logic [7:0] f);
    for (int k = 0; k < 4; k++) begin
      din[k] = (k < 2) ? d : '0;
      dv[k]  = (k < 2) ? v : 1'b0;
      st[k]  = (k < 2) ? s : '0;
      fl[k]  = (k < 2) ? f : '0;
    end
  endtask

  initial begin
    model_reset();
    drive('0, 1'b0, '0, '0);
    #2;
    for (int k = 0; k < 4; k++) check_dut(k);
    @(posedge clk);
    #1 rst = 1'b0;

    // Streaming 1, 2, 3.
    for (int n = 1; n <= 3; n++) begin
      drive(n, 1'b1, '0, '0);
      step();
    end
    check("stream_q", 256'(q_a), 256'({15'h0001, 15'h0002, 15'h0003}));
    check("stream_v", 256'(qv_a), 256'(3'b111));
    check("stream_occ", 256'(occ_a), 256'(2'd3));

    // Asynchronous reset with a full chain, then refill.
    async_reset();
    check("rst_q", 256'(q_a), 256'(0));
    for (int n = 1; n <= 3; n++) begin
      drive(n, 1'b1, '0, '0);
      step();
    end

    // Middle-stage stall: stages 0/1 hold, stage 2 drains to a bubble.
    drive(32'h4, 1'b1, 8'b010, '0);
    #1 check("mid_rdy", 256'(rdy_a), 256'(0));
    step();
    check("mid_q", 256'(q_a), 256'({15'h0000, 15'h0002, 15'h0003}));
    check("mid_v", 256'(qv_a), 256'(3'b011));
    check("mid_occ", 256'(occ_a), 256'(2'd2));

    // Last-stage stall freezes everything for two edges, then 4 enters in order.
    for (int n = 0; n < 2; n++) begin
      drive(32'h4, 1'b1, 8'b100, '0);
      #1 check("last_rdy", 256'(rdy_a), 256'(0));
      step();
    end
    drive(32'h4, 1'b1, '0, '0);
    step();
    check("resume_q", 256'(q_a), 256'({15'h0002, 15'h0003, 15'h0004}));
    check("resume_v", 256'(qv_a), 256'(3'b111));

    // Flush beats stall on stage 0.
    drive(32'hAA, 1'b1, '0, '0);
    step();
    drive('0, 1'b0, 8'b001, 8'b001);
    step();
    check("flush_clr_dat", 256'(q_a[14:0]), 256'(0));
    check("flush_clr_v", 256'(qv_a[0]), 256'(0));
    check("flush_hold_dat", 256'(q_b[14:0]), 256'(15'h00AA));
    check("flush_hold_v", 256'(qv_b[0]), 256'(0));

    // Random phase on all configurations.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < 4; k++) begin
        din[k] = $urandom;
        if (cfg_w[k] < 32) din[k] = din[k] & ((32'd1 << cfg_w[k]) - 1);
        dv[k] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 8; i++) begin
          st[k][i] = ($urandom_range(0, 7) == 0);
          fl[k][i] = ($urandom_range(0, 15) == 0);
        end
      end
      step();
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
